// File: rtl/state_event_logger_if.sv
// Readout/status bundle between the state event logger and whatever drives it.
// Master drives valid/clear/select and receives the byte, event pulse and fault flag.
interface state_event_logger_if;
   logic       i_valid;
   logic       i_clear;
   logic [2:0] i_sel;
   logic [7:0] o_data;
   logic       o_event;
   logic       o_fault;

   modport master (
      output i_valid, i_clear, i_sel,
      input  o_data, o_event, o_fault
   );

   modport slave (
      input  i_valid, i_clear, i_sel,
      output o_data, o_event, o_fault
   );
endinterface

// File: rtl/state_event_logger.sv
// Counts valid->invalid events, times invalid intervals, keeps last/max length (max under STATE_EVENT_LOGGER_MAXDUR_EN).
// Latency: event/fault one cycle after the sampled edge; readout byte registered, one cycle.
// Backpressure: none; the source is sampled every cycle and reads are free-running.
module state_event_logger #(
   parameter int CNT_W = 8,
   parameter int DUR_W = 16
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   state_event_logger_if.slave   bus
);

   localparam logic [0:0] S_OK    = 1'b0;
   localparam logic [0:0] S_FAULT = 1'b1;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [DUR_W-1:0] DUR_MAX = '1;

   logic [0:0]       state_q,    state_d;
   logic [CNT_W-1:0] evt_cnt_q,  evt_cnt_d;
   logic [DUR_W-1:0] cur_dur_q,  cur_dur_d;
   logic [DUR_W-1:0] last_dur_q, last_dur_d;
   logic             cnt_sat_q,  cnt_sat_d;
   logic             dur_sat_q,  dur_sat_d;
   logic             fault_q,    fault_d;
   logic             event_q,    event_d;
   logic [7:0]       data_q,     data_d;
`ifdef STATE_EVENT_LOGGER_MAXDUR_EN
   logic [DUR_W-1:0] max_dur_q,  max_dur_d;
`endif

   logic [15:0] last_ext;
   logic [15:0] max_ext;

   always_comb begin
      // Clear is folded in first so a same-cycle event or record lands on top of it.
      state_d    = state_q;
      cur_dur_d  = cur_dur_q;
      event_d    = 1'b0;
      evt_cnt_d  = bus.i_clear ? '0   : evt_cnt_q;
      last_dur_d = bus.i_clear ? '0   : last_dur_q;
      cnt_sat_d  = bus.i_clear ? 1'b0 : cnt_sat_q;
      dur_sat_d  = bus.i_clear ? 1'b0 : dur_sat_q;
      fault_d    = bus.i_clear ? 1'b0 : fault_q;
`ifdef STATE_EVENT_LOGGER_MAXDUR_EN
      max_dur_d  = bus.i_clear ? '0   : max_dur_q;
`endif

      case (state_q)
         S_OK: begin
            if (!bus.i_valid) begin
               state_d   = S_FAULT;
               event_d   = 1'b1;
               fault_d   = 1'b1;
               cur_dur_d = DUR_W'(1);
               if (evt_cnt_d != CNT_MAX) evt_cnt_d = evt_cnt_d + CNT_W'(1);
               if (evt_cnt_d == CNT_MAX) cnt_sat_d = 1'b1;
               if (cur_dur_d == DUR_MAX) dur_sat_d = 1'b1;
            end
         end
         default: begin
            if (!bus.i_valid) begin
               if (cur_dur_q != DUR_MAX) cur_dur_d = cur_dur_q + DUR_W'(1);
               if (cur_dur_d == DUR_MAX) dur_sat_d = 1'b1;
            end else begin
               state_d    = S_OK;
               last_dur_d = cur_dur_q;
`ifdef STATE_EVENT_LOGGER_MAXDUR_EN
               if (cur_dur_q > max_dur_d) max_dur_d = cur_dur_q;
`endif
            end
         end
      endcase
   end

   always_comb begin
      last_ext = 16'(last_dur_q);
`ifdef STATE_EVENT_LOGGER_MAXDUR_EN
      max_ext  = 16'(max_dur_q);
`else
      max_ext  = 16'h0000;
`endif
      data_d = 8'h00;
      case (bus.i_sel)
         3'b000:  data_d = 8'(evt_cnt_q);
         3'b001:  data_d = max_ext[7:0];
         3'b010:  data_d = max_ext[15:8];
         3'b011:  data_d = last_ext[7:0];
         3'b100:  data_d = last_ext[15:8];
         3'b101:  data_d = {4'b0000, cnt_sat_q, dur_sat_q, (state_q == S_FAULT), fault_q};
         default: data_d = 8'h00;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= S_OK;
         evt_cnt_q  <= '0;
         cur_dur_q  <= '0;
         last_dur_q <= '0;
         cnt_sat_q  <= 1'b0;
         dur_sat_q  <= 1'b0;
         fault_q    <= 1'b0;
         event_q    <= 1'b0;
         data_q     <= 8'h00;
      end else begin
         state_q    <= state_d;
         evt_cnt_q  <= evt_cnt_d;
         cur_dur_q  <= cur_dur_d;
         last_dur_q <= last_dur_d;
         cnt_sat_q  <= cnt_sat_d;
         dur_sat_q  <= dur_sat_d;
         fault_q    <= fault_d;
         event_q    <= event_d;
         data_q     <= data_d;
      end
   end

`ifdef STATE_EVENT_LOGGER_MAXDUR_EN
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) max_dur_q <= '0;
      else          max_dur_q <= max_dur_d;
   end
`endif

   assign bus.o_data  = data_q;
   assign bus.o_event = event_q;
   assign bus.o_fault = fault_q;

endmodule
